// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: CSR field offsets,
// the stored entry layout and pointer sizing.
package uart_pkg;

    localparam int THRESH_LSB    = 0;
    localparam int THRESH_MSB    = 7;
    localparam int TMO_LSB       = 16;
    localparam int TMO_MSB       = 31;
    localparam int RX_DATA_WIDTH = 8;

    typedef struct packed {
        logic                     error;
        logic [RX_DATA_WIDTH-1:0] data;
    } rx_entry_t;

    // A one-bit pointer still needs one bit, so depth 2 maps to width 1.
    function automatic int ptr_width(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/rx_fifo_mem.sv
// Storage array for rx_fifo: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module rx_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int WIDTH = 9
) (
    input  logic                         clock,
    input  logic                         we_i,
    input  logic [ptr_width(DEPTH)-1:0]  waddr_i,
    input  logic [WIDTH-1:0]             wdata_i,
    input  logic [ptr_width(DEPTH)-1:0]  raddr_i,
    output logic [WIDTH-1:0]             rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write port.
    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rx_fifo.sv
// First-word-fall-through receive FIFO behind the UART receiver, with
// occupancy, overflow, threshold and idle-timeout status.
module rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH        = 32,
    parameter int DATA_WIDTH   = 8,
    parameter int CONFIG_WIDTH = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       din_valid,
    input  logic [DATA_WIDTH-1:0]      din,
    input  logic                       din_error,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    output logic [DATA_WIDTH-1:0]      dout,
    output logic                       dout_error,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       thresh_hit,
    output logic                       timeout,
    input  logic                       flush,
    input  logic                       clear,
    input  logic [CONFIG_WIDTH-1:0]    fifo_conf
);

    localparam int PW = ptr_width(DEPTH);
    localparam int LW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic                  error;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          overflow_q, overflow_d;
    logic          timeout_q, timeout_d;
    logic [31:0]   idle_q, idle_d;

    logic          empty_s, full_s, push_s, pop_s, drop_s, tmo_set_s;
    logic [7:0]    thresh_s;
    logic [15:0]   limit_s;
    entry_t        wr_entry_s, rd_entry_s;
    logic          unused_conf_s;

    assign empty_s   = (level_q == {LW{1'b0}});
    assign full_s    = (level_q == LW'(DEPTH));
    assign thresh_s  = fifo_conf[THRESH_MSB:THRESH_LSB];
    assign limit_s   = fifo_conf[TMO_MSB:TMO_LSB];
    assign unused_conf_s = ^fifo_conf[TMO_LSB-1:THRESH_MSB+1];

    // Flush dominates: it suppresses both the write and any drop indication.
    assign pop_s  = dout_ready & ~empty_s & ~flush;
    assign push_s = din_valid & (~full_s | pop_s) & ~flush;
    assign drop_s = din_valid & full_s & ~pop_s & ~flush;

    assign wr_entry_s = '{error: din_error, data: din};

    rx_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_WIDTH + 1)
    ) u_mem (
        .clock   (clock),
        .we_i    (push_s),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry_s),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry_s)
    );

    // Pointer, level and sticky next-state.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = drop_s | (overflow_q & ~clear);
        timeout_d  = tmo_set_s | (timeout_q & ~clear);
        if (flush) begin
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
            level_d  = {LW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (push_s && !pop_s) begin
                level_d = level_q + LW'(1);
            end else if (pop_s && !push_s) begin
                level_d = level_q - LW'(1);
            end else begin
                level_d = level_q;
            end
        end
    end

    // Idle counter: saturates one below the limit while raising the timeout.
    always_comb begin
        idle_d    = idle_q;
        tmo_set_s = 1'b0;
        if (flush || push_s || empty_s || (limit_s == 16'd0)) begin
            idle_d = 32'd0;
        end else if (idle_q == ({16'd0, limit_s} - 32'd1)) begin
            idle_d    = idle_q;
            tmo_set_s = 1'b1;
        end else begin
            idle_d = idle_q + 32'd1;
        end
    end

    // State registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            level_q    <= {LW{1'b0}};
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
            idle_q     <= 32'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            timeout_q  <= timeout_d;
            idle_q     <= idle_d;
        end
    end

    assign dout_valid = ~empty_s;
    assign dout       = rd_entry_s.data;
    assign dout_error = rd_entry_s.error;
    assign level      = level_q;
    assign empty      = empty_s;
    assign full       = full_s;
    assign overflow   = overflow_q;
    assign timeout    = timeout_q;
    // A zero threshold field disables the indication entirely.
    assign thresh_hit = (thresh_s != 8'd0) && (32'(level_q) >= 32'(thresh_s));

endmodule

// File: tb/tb_rx_fifo.sv
// Directed bench for rx_fifo with hand-computed expectations.
module tb_rx_fifo;

    logic        clock = 1'b0;
    logic        reset;
    logic        din_valid, din_error, dout_ready, flush, clear;
    logic [7:0]  din;
    logic        dout_valid, dout_error, empty, full, overflow, thresh_hit, timeout;
    logic [7:0]  dout;
    logic [5:0]  level;
    logic [31:0] fifo_conf;

    int vectors_applied = 0;
    int miscompares     = 0;

    rx_fifo dut (
        .clock      (clock),
        .reset      (reset),
        .din_valid  (din_valid),
        .din        (din),
        .din_error  (din_error),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout       (dout),
        .dout_error (dout_error),
        .level      (level),
        .empty      (empty),
        .full       (full),
        .overflow   (overflow),
        .thresh_hit (thresh_hit),
        .timeout    (timeout),
        .flush      (flush),
        .clear      (clear),
        .fifo_conf  (fifo_conf)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors_applied++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d, input logic e);
        din_valid = 1'b1;
        din       = d;
        din_error = e;
        tick();
        din_valid = 1'b0;
        din_error = 1'b0;
    endtask

    task automatic pop_one();
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; din_valid = 1'b0; din = 8'h00; din_error = 1'b0;
        dout_ready = 1'b0; flush = 1'b0; clear = 1'b0; fifo_conf = 32'd0;
        #12 reset = 1'b0;
        tick();

        // 1: reset state and basic ordering with error flag
        chk("rst_valid", dout_valid, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_level", level, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_tmo", timeout, 0);
        chk("rst_thr", thresh_hit, 0);
        push_byte(8'h55, 1'b0);
        chk("fwft_valid", dout_valid, 1);
        chk("fwft_dout", dout, 8'h55);
        push_byte(8'hA3, 1'b1);
        chk("t1_level", level, 2);
        chk("t1_dout0", dout, 8'h55);
        chk("t1_err0", dout_error, 0);
        pop_one();
        chk("t1_dout1", dout, 8'hA3);
        chk("t1_err1", dout_error, 1);
        pop_one();
        chk("t1_empty", empty, 1);

        // 2: fill past capacity, then drain in order
        for (int i = 0; i < 33; i++) begin
            push_byte(8'(i), 1'b0);
            if (i == 30) chk("t2_notfull", full, 0);
            if (i == 31) begin
                chk("t2_full", full, 1);
                chk("t2_noovf", overflow, 0);
            end
        end
        chk("t2_ovf", overflow, 1);
        chk("t2_level", level, 32);
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("t2_drain%0d", i), dout, 32'(i));
            pop_one();
        end
        chk("t2_empty", empty, 1);
        chk("t2_ovf_sticky", overflow, 1);
        clear = 1'b1; tick(); clear = 1'b0;
        chk("t2_clear", overflow, 0);

        // 3: push and pop together while full
        for (int i = 0; i < 32; i++) push_byte(8'(i), 1'b0);
        din_valid = 1'b1; din = 8'h7E; dout_ready = 1'b1;
        tick();
        din_valid = 1'b0; dout_ready = 1'b0;
        chk("t3_noovf", overflow, 0);
        chk("t3_level", level, 32);
        for (int i = 1; i < 32; i++) begin
            chk($sformatf("t3_pop%0d", i), dout, 32'(i));
            pop_one();
        end
        chk("t3_last", dout, 8'h7E);
        chk("t3_lvl1", level, 1);
        pop_one();
        chk("t3_empty", empty, 1);

        // 4: threshold
        fifo_conf = 32'h0000_0004;
        for (int i = 0; i < 3; i++) push_byte(8'(i), 1'b0);
        chk("t4_below", thresh_hit, 0);
        push_byte(8'h03, 1'b0);
        chk("t4_at", thresh_hit, 1);
        pop_one();
        chk("t4_after_pop", thresh_hit, 0);
        fifo_conf = 32'h0000_0000;
        #1 chk("t4_zero_lvl3", thresh_hit, 0);
        flush = 1'b1; tick(); flush = 1'b0;
        chk("t4_zero_empty", thresh_hit, 0);
        chk("t4_flushed", level, 0);

        // 5: idle timeout
        fifo_conf = {16'd100, 16'd0};
        push_byte(8'h11, 1'b0);
        idle(98);
        chk("t5_early98", timeout, 0);
        tick();
        chk("t5_early99", timeout, 0);
        tick();
        chk("t5_at100", timeout, 1);
        pop_one();
        chk("t5_drained", empty, 1);
        chk("t5_sticky", timeout, 1);
        clear = 1'b1; tick(); clear = 1'b0;
        chk("t5_clear", timeout, 0);
        push_byte(8'h22, 1'b0);
        idle(49);
        push_byte(8'h33, 1'b0);
        chk("t5_restart50", timeout, 0);
        idle(99);
        chk("t5_restart99", timeout, 0);
        tick();
        chk("t5_restart100", timeout, 1);
        flush = 1'b1; clear = 1'b1; tick(); flush = 1'b0; clear = 1'b0;
        fifo_conf = 32'd0;
        tick();
        chk("t5_cleanup", timeout, 0);

        // 6: asynchronous reset mid-cycle, then flush with a concurrent push
        for (int i = 0; i < 5; i++) push_byte(8'(8'h40 + i), 1'b0);
        chk("t6_lvl5", level, 5);
        #3 reset = 1'b1;
        #1;
        chk("t6_rst_valid", dout_valid, 0);
        chk("t6_rst_level", level, 0);
        chk("t6_rst_empty", empty, 1);
        #2 reset = 1'b0;
        tick();
        for (int i = 0; i < 32; i++) push_byte(8'(i), 1'b0);
        chk("t6_full", full, 1);
        flush = 1'b1; din_valid = 1'b1; din = 8'h99;
        tick();
        flush = 1'b0; din_valid = 1'b0;
        chk("t6_fl_level", level, 0);
        chk("t6_fl_ovf", overflow, 0);
        chk("t6_fl_empty", empty, 1);
        push_byte(8'hC4, 1'b1);
        chk("t6_post_dout", dout, 8'hC4);
        chk("t6_post_err", dout_error, 1);
        chk("t6_post_lvl", level, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
